ctrl_unit: RTL and testbench
============================

Name: ctrl_unit

Overview:
Main decoder and ALU decoder for the single-cycle RV32I core. It maps opcode, funct3 and funct7 to datapath selects, write enables and the ALU operation. It resolves the next-PC select from the external branch comparison result. Decode is purely combinational. The one registered element is a sticky illegal-instruction flag; reset also gates all write enables to their safe values.

Parameters:
none

Ports:
clk  in  1  core clock; used only by the sticky flag
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7  in  7  instr[31:25]
BranchRes  in  1  1 = branch condition for the current funct3 holds, computed by the external comparator
PCSrc  out  1  0 = PC+4, 1 = branch/jump target
RegWrite  out  1  register file write enable
ImmSrc  out  3  immediate format: I=000, S=001, B=010, J=011, U=100
Branch  out  1  instruction is a conditional branch
ALUSrcA  out  1  0 = rs1, 1 = PC
ALUSrcB  out  1  0 = rs2, 1 = immediate
ALUControl  out  4  ALU operation (encoding in Behaviour)
StoreModCtrl  out  1  sub-word store merge enable (SB, SH)
MemWrite  out  1  data memory write enable
LdModCtrl  out  1  sub-word load extract enable (LB, LH, LBU, LHU)
LdMuxCtrl  out  1  load extension: 0 = sign, 1 = zero (funct3[2]); 0 when not a load
ResultSrc  out  2  write-back select: 00 = ALU, 01 = load data, 10 = PC+4, 11 = immediate
IllegalInstr  out  1  combinational: current encoding is not supported
IllegalSeen  out  1  registered sticky flag

Behaviour:
- Internal nets named Jump and auipc must exist; test benches probe them hierarchically.
- PCSrc = Jump | (Branch & BranchRes).
- ALUControl encoding:
  - ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101
  - SRL 0110, SRA 0111, OR 1000, AND 1001
- Default for every output: 0, ImmSrc 000, ALUControl ADD.
- R-type, 0110011:
  - RegWrite 1; ALUSrcA 0; ALUSrcB 0; ResultSrc 00; ImmSrc 000.
  - ALU op from funct3: 000 ADD or SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL or SRA, 110 OR, 111 AND.
  - funct7 = 0100000 selects SUB (funct3 000) or SRA (funct3 101).
  - funct7 = 0000000 selects the base op. Any other funct7, or 0100000 with another funct3, is illegal.
- I-ALU, 0010011:
  - RegWrite 1; ALUSrcB 1; ImmSrc 000; same funct3 map as R-type, but funct3 000 is always ADD.
  - Shifts (funct3 001, 101): funct7 must be 0000000, except 0100000 with funct3 101 gives SRA. Otherwise illegal.
- Load, 0000011:
  - RegWrite 1; ALUSrcB 1; ImmSrc 000; ADD; ResultSrc 01.
  - LdModCtrl = 1 unless funct3 = 010; LdMuxCtrl = funct3[2].
  - Legal funct3: 000, 001, 010, 100, 101.
- Store, 0100011:
  - MemWrite 1; ALUSrcB 1; ImmSrc 001; ADD.
  - StoreModCtrl = 1 for funct3 000 or 001. Legal funct3: 000, 001, 010.
- Branch, 1100011:
  - Branch 1; ImmSrc 010; ALUSrcA 0; ALUSrcB 0.
  - ALU op: SUB for funct3 000/001, SLT for 100/101, SLTU for 110/111; 010/011 are illegal.
  - The branch target comes from a separate adder.
- JAL, 1101111: Jump 1; RegWrite 1; ImmSrc 011; ALUSrcA 1; ALUSrcB 1; ADD; ResultSrc 10.
- JALR, 1100111: Jump 1; RegWrite 1; ImmSrc 000; ALUSrcA 0; ALUSrcB 1; ADD; ResultSrc 10. funct3 must be 000.
- LUI, 0110111: RegWrite 1; ImmSrc 100; ResultSrc 11.
- AUIPC, 0010111: auipc 1; RegWrite 1; ImmSrc 100; ALUSrcA 1; ALUSrcB 1; ADD; ResultSrc 00.
- FENCE 0001111 and SYSTEM 1110011: NOP (all defaults), not illegal.
- Illegal encodings (any other opcode, or an illegal funct field):
  - IllegalInstr 1; RegWrite, MemWrite, Branch, Jump, PCSrc all 0; other outputs at defaults.
- Reset and sticky flag:
  - While rst_n = 0: RegWrite, MemWrite, PCSrc and StoreModCtrl are forced to 0. Other outputs keep decoding.
  - IllegalSeen clears asynchronously to 0 on reset.
  - On each rising clk edge with rst_n = 1, IllegalSeen <= IllegalSeen | IllegalInstr. It is cleared only by reset.

Test Plan:
- rst_n 1; opcode 0110011, funct3 101, funct7 0100000, BranchRes 0 → ALUControl 0111, RegWrite 1, ALUSrcA 0, ALUSrcB 0, ResultSrc 00, ImmSrc 000, PCSrc 0, Jump 0, auipc 0, MemWrite 0, Branch 0, Ld/Store ctrls 0.
- Branch: opcode 1100011, funct3 101 → Branch 1, ALUControl 0011, ImmSrc 010. BranchRes 0 gives PCSrc 0; BranchRes 1 gives PCSrc 1.
- Loads and stores:
  - LBU (0000011, funct3 100) → ResultSrc 01, LdModCtrl 1, LdMuxCtrl 1.
  - LW (funct3 010) → LdModCtrl 0.
  - SH (0100011, funct3 001) → MemWrite 1, StoreModCtrl 1, ImmSrc 001.
- Jumps and upper immediates:
  - JAL → PCSrc 1 regardless of BranchRes, ResultSrc 10, ALUSrcA 1, ImmSrc 011.
  - AUIPC → auipc 1, ALUSrcA 1, ImmSrc 100.
  - LUI → ResultSrc 11.
- Illegal instruction:
  - opcode 1111111 → IllegalInstr 1, RegWrite 0, MemWrite 0, PCSrc 0; IllegalSeen rises after the next clk edge.
  - R-type funct7 0000001 → IllegalInstr 1.
- Reset: assert rst_n 0 mid-run with an ADD instruction applied → RegWrite 0 and IllegalSeen 0 immediately, without waiting for clk; release → RegWrite 1.

Source files
------------

// File: rtl/ctrl_unit.sv
// RV32I main and ALU decoder with a sticky illegal-instruction flag.
// Decode is combinational; only IllegalSeen is registered.
module ctrl_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       BranchRes,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic [2:0] ImmSrc,
  output logic       Branch,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [3:0] ALUControl,
  output logic       StoreModCtrl,
  output logic       MemWrite,
  output logic       LdModCtrl,
  output logic       LdMuxCtrl,
  output logic [1:0] ResultSrc,
  output logic       IllegalInstr,
  output logic       IllegalSeen
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  logic Jump;
  logic auipc;

  logic       ill;
  logic       regw;
  logic       memw;
  logic       br;
  logic       jmp;
  logic       aui;
  logic       asa;
  logic       asb;
  logic       smc;
  logic       ldm;
  logic       ldx;
  logic [2:0] imm;
  logic [3:0] alu;
  logic [1:0] res;
  logic [3:0] alu_base;

  logic is_r, is_i, is_ld, is_st, is_br;
  logic is_jal, is_jalr, is_lui, is_aui, is_nop;

  logic illegal_seen_q;
  logic illegal_seen_d;

  assign is_r    = (opcode == OP_R);
  assign is_i    = (opcode == OP_I);
  assign is_ld   = (opcode == OP_LOAD);
  assign is_st   = (opcode == OP_STORE);
  assign is_br   = (opcode == OP_BR);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);
  assign is_lui  = (opcode == OP_LUI);
  assign is_aui  = (opcode == OP_AUIPC);
  assign is_nop  = (opcode == OP_FENCE) | (opcode == OP_SYS);

  always_comb begin
    alu_base = ALU_ADD;
    unique case (funct3)
      3'b000: alu_base = ALU_ADD;
      3'b001: alu_base = ALU_SLL;
      3'b010: alu_base = ALU_SLT;
      3'b011: alu_base = ALU_SLTU;
      3'b100: alu_base = ALU_XOR;
      3'b101: alu_base = ALU_SRL;
      3'b110: alu_base = ALU_OR;
      3'b111: alu_base = ALU_AND;
      default: alu_base = ALU_ADD;
    endcase
  end

  always_comb begin
    ill  = 1'b0;
    regw = 1'b0;
    memw = 1'b0;
    br   = 1'b0;
    jmp  = 1'b0;
    aui  = 1'b0;
    asa  = 1'b0;
    asb  = 1'b0;
    smc  = 1'b0;
    ldm  = 1'b0;
    ldx  = 1'b0;
    imm  = IMM_I;
    alu  = ALU_ADD;
    res  = RES_ALU;
    unique case (1'b1)
      is_r: begin
        regw = 1'b1;
        alu  = alu_base;
        if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            alu = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            alu = ALU_SRA;
          end else begin
            ill = 1'b1;
          end
        end else if (funct7 != F7_BASE) begin
          ill = 1'b1;
        end
      end
      is_i: begin
        regw = 1'b1;
        asb  = 1'b1;
        alu  = alu_base;
        // funct7 only qualifies the shift-immediate forms
        if (funct3 == 3'b001) begin
          ill = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) begin
            alu = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            ill = 1'b1;
          end
        end
      end
      is_ld: begin
        regw = 1'b1;
        asb  = 1'b1;
        res  = RES_MEM;
        ldm  = (funct3 != 3'b010);
        ldx  = funct3[2];
        ill  = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
      end
      is_st: begin
        memw = 1'b1;
        asb  = 1'b1;
        imm  = IMM_S;
        smc  = (funct3[2:1] == 2'b00);
        ill  = funct3[2] | (funct3 == 3'b011);
      end
      is_br: begin
        br  = 1'b1;
        imm = IMM_B;
        unique case (funct3[2:1])
          2'b00:   alu = ALU_SUB;
          2'b10:   alu = ALU_SLT;
          2'b11:   alu = ALU_SLTU;
          default: ill = 1'b1;
        endcase
      end
      is_jal: begin
        jmp  = 1'b1;
        regw = 1'b1;
        imm  = IMM_J;
        asa  = 1'b1;
        asb  = 1'b1;
        res  = RES_PC4;
      end
      is_jalr: begin
        jmp  = 1'b1;
        regw = 1'b1;
        asb  = 1'b1;
        res  = RES_PC4;
        ill  = (funct3 != 3'b000);
      end
      is_lui: begin
        regw = 1'b1;
        imm  = IMM_U;
        res  = RES_IMM;
      end
      is_aui: begin
        aui  = 1'b1;
        regw = 1'b1;
        imm  = IMM_U;
        asa  = 1'b1;
        asb  = 1'b1;
      end
      is_nop: begin
        ill = 1'b0;
      end
      default: begin
        ill = 1'b1;
      end
    endcase
    // an unsupported encoding must leave no side effects at all
    if (ill) begin
      regw = 1'b0;
      memw = 1'b0;
      br   = 1'b0;
      jmp  = 1'b0;
      aui  = 1'b0;
      asa  = 1'b0;
      asb  = 1'b0;
      smc  = 1'b0;
      ldm  = 1'b0;
      ldx  = 1'b0;
      imm  = IMM_I;
      alu  = ALU_ADD;
      res  = RES_ALU;
    end
  end

  assign Jump         = jmp;
  assign auipc        = aui;
  assign IllegalInstr = ill;
  assign Branch       = br;
  assign ImmSrc       = imm;
  assign ALUSrcA      = asa;
  assign ALUSrcB      = asb;
  assign ALUControl   = alu;
  assign LdModCtrl    = ldm;
  assign LdMuxCtrl    = ldx;
  assign ResultSrc    = res;

  // state-changing enables are held off while reset is asserted
  assign RegWrite     = regw & rst_n;
  assign MemWrite     = memw & rst_n;
  assign StoreModCtrl = smc & rst_n;
  assign PCSrc        = (Jump | (br & BranchRes)) & rst_n;

  always_comb begin
    illegal_seen_d = illegal_seen_q | ill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen_q <= 1'b0;
    end else begin
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign IllegalSeen = illegal_seen_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// Scoreboard bench for ctrl_unit: driver pushes model predictions,
// monitor pops and compares on the falling clock edge.
module tb_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       BranchRes;
  logic       PCSrc;
  logic       RegWrite;
  logic [2:0] ImmSrc;
  logic       Branch;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic [3:0] ALUControl;
  logic       StoreModCtrl;
  logic       MemWrite;
  logic       LdModCtrl;
  logic       LdMuxCtrl;
  logic [1:0] ResultSrc;
  logic       IllegalInstr;
  logic       IllegalSeen;

  ctrl_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .BranchRes    (BranchRes),
    .PCSrc        (PCSrc),
    .RegWrite     (RegWrite),
    .ImmSrc       (ImmSrc),
    .Branch       (Branch),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUControl   (ALUControl),
    .StoreModCtrl (StoreModCtrl),
    .MemWrite     (MemWrite),
    .LdModCtrl    (LdModCtrl),
    .LdMuxCtrl    (LdMuxCtrl),
    .ResultSrc    (ResultSrc),
    .IllegalInstr (IllegalInstr),
    .IllegalSeen  (IllegalSeen)
  );

  typedef struct packed {
    logic       ill;
    logic       seen;
    logic       jump;
    logic       aui;
    logic       pcsrc;
    logic       regw;
    logic [2:0] imm;
    logic       br;
    logic       asa;
    logic       asb;
    logic [3:0] alu;
    logic       smc;
    logic       memw;
    logic       ldm;
    logic       ldx;
    logic [1:0] res;
  } exp_t;

  typedef struct packed {
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       brr;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;
  logic seen_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic brr,
                                 input logic rst);
    exp_t e;
    bit ok;
    logic [3:0] base [8];
    base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    e = '0;
    ok = 1;
    case (op)
      7'b0110011: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.regw = 1;
        e.alu = base[f3];
        if (f7 == 7'h20 && f3 == 0) e.alu = 4'd1;
        if (f7 == 7'h20 && f3 == 5) e.alu = 4'd7;
      end
      7'b0010011: begin
        ok = (f3 != 1 && f3 != 5) || f7 == 7'h00 || (f3 == 5 && f7 == 7'h20);
        e.regw = 1; e.asb = 1;
        e.alu = base[f3];
        if (f3 == 5 && f7 == 7'h20) e.alu = 4'd7;
      end
      7'b0000011: begin
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        e.regw = 1; e.asb = 1; e.res = 2'd1;
        e.ldm = (f3 != 2); e.ldx = f3[2];
      end
      7'b0100011: begin
        ok = (f3 <= 2);
        e.memw = 1; e.asb = 1; e.imm = 3'd1;
        e.smc = (f3 < 2);
      end
      7'b1100011: begin
        ok = (f3 != 2 && f3 != 3);
        e.br = 1; e.imm = 3'd2;
        e.alu = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd3 : 4'd4;
      end
      7'b1101111: begin
        e.jump = 1; e.regw = 1; e.imm = 3'd3;
        e.asa = 1; e.asb = 1; e.res = 2'd2;
      end
      7'b1100111: begin
        ok = (f3 == 0);
        e.jump = 1; e.regw = 1; e.asb = 1; e.res = 2'd2;
      end
      7'b0110111: begin
        e.regw = 1; e.imm = 3'd4; e.res = 2'd3;
      end
      7'b0010111: begin
        e.aui = 1; e.regw = 1; e.imm = 3'd4; e.asa = 1; e.asb = 1;
      end
      7'b0001111, 7'b1110011: ok = 1;
      default: ok = 0;
    endcase
    if (!ok) begin
      e = '0;
      e.ill = 1;
    end
    e.pcsrc = e.jump | (e.br & brr);
    if (!rst) begin
      e.regw = 0; e.memw = 0; e.pcsrc = 0; e.smc = 0;
    end
    return e;
  endfunction

  // sticky flag reference: accumulates legality of whatever is applied
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen_m <= 1'b0;
    else seen_m <= seen_m | model(opcode, funct3, funct7, BranchRes, 1'b1).ill;
  end

  function automatic exp_t actual();
    exp_t a;
    a.ill = IllegalInstr; a.seen = IllegalSeen;
    a.jump = dut.Jump; a.aui = dut.auipc;
    a.pcsrc = PCSrc; a.regw = RegWrite; a.imm = ImmSrc;
    a.br = Branch; a.asa = ALUSrcA; a.asb = ALUSrcB;
    a.alu = ALUControl; a.smc = StoreModCtrl; a.memw = MemWrite;
    a.ldm = LdModCtrl; a.ldx = LdMuxCtrl; a.res = ResultSrc;
    return a;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      exp_t a;
      it = q.pop_front();
      a = actual();
      checks++;
      if (a !== it.e) begin
        errors++;
        $display("FAIL decode op=%b f3=%b f7=%b br=%b got=%h exp=%h",
                 it.op, it.f3, it.f7, it.brr, a, it.e);
      end
    end
  end

  task automatic apply(input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic brr);
    item_t it;
    @(posedge clk);
    #1;
    opcode = op; funct3 = f3; funct7 = f7; BranchRes = brr;
    #0;
    it.op = op; it.f3 = f3; it.f7 = f7; it.brr = brr;
    it.e = model(op, f3, f7, brr, rst_n);
    it.e.seen = seen_m;
    q.push_back(it);
  endtask

  task automatic chk(input string nm, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", nm, got, req);
    end
  endtask

  logic [6:0] ops [12];
  initial begin
    int budget;
    logic [6:0] op;
    logic [6:0] f7;
    int r;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
            7'b0010111, 7'b0001111, 7'b1110011, 7'b1111111};
    rst_n = 1'b0;
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'h00; BranchRes = 1'b0;
    #12;
    chk("reset_seen", IllegalSeen, 1'b0);
    chk("reset_regwrite", RegWrite, 1'b0);
    rst_n = 1'b1;

    apply(7'b0110011, 3'b101, 7'h20, 1'b0);
    apply(7'b1100011, 3'b101, 7'h00, 1'b0);
    apply(7'b1100011, 3'b101, 7'h00, 1'b1);
    apply(7'b0000011, 3'b100, 7'h00, 1'b0);
    apply(7'b0000011, 3'b010, 7'h00, 1'b0);
    apply(7'b0100011, 3'b001, 7'h00, 1'b0);
    apply(7'b1101111, 3'b010, 7'h00, 1'b0);
    apply(7'b1101111, 3'b110, 7'h00, 1'b1);
    apply(7'b0010111, 3'b000, 7'h00, 1'b0);
    apply(7'b0110111, 3'b000, 7'h00, 1'b0);
    apply(7'b0010011, 3'b101, 7'h20, 1'b0);
    apply(7'b0010011, 3'b000, 7'h55, 1'b0);
    apply(7'b1100111, 3'b001, 7'h00, 1'b1);
    apply(7'b1111111, 3'b000, 7'h00, 1'b1);
    apply(7'b0110011, 3'b000, 7'h01, 1'b0);
    apply(7'b0110011, 3'b000, 7'h00, 1'b0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 8) ? ops[$urandom_range(0, 11)] : 7'($urandom);
      r = $urandom_range(0, 9);
      f7 = (r < 5) ? 7'h00 : (r < 8) ? 7'h20 : 7'($urandom);
      apply(op, 3'($urandom), f7, 1'($urandom));
    end

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain got=%0d exp=0", q.size());
      q.delete();
    end

    @(posedge clk);
    #1;
    opcode = 7'b1111111;
    @(negedge clk);
    #2;
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'h00;
    #1;
    chk("pre_reset_seen", IllegalSeen, 1'b1);
    chk("pre_reset_regwrite", RegWrite, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_regwrite", RegWrite, 1'b0);
    chk("async_reset_seen", IllegalSeen, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("release_regwrite", RegWrite, 1'b1);
    chk("release_seen", IllegalSeen, 1'b0);

    for (int i = 0; i < 40; i++) begin
      apply(ops[$urandom_range(0, 11)], 3'($urandom), 7'h00, 1'($urandom));
    end
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
